// File: rtl/button_debounce_bank.sv
// Multi-channel button conditioner: 2-flop synchroniser, debounced level,
// press/release pulses, per-channel lockout window and optional auto-repeat.
module button_debounce_bank #(
    parameter int CHANNELS = 4,
    parameter int LOCKOUT  = 16,
    parameter int REPEAT   = 0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                en,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] held,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] rpt
);
    // state      | meaning
    // ST_IDLE    | debounced level low, waiting for an accepted press
    // ST_PRESSED | debounced level high, waiting for an accepted release
    // Lockout (lock_q != 0) is orthogonal to both states.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_t;

    localparam int LW = $clog2(LOCKOUT + 1);
    localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT);
    localparam logic [RW-1:0] RPT_LAST  = (REPEAT > 0) ? RW'(REPEAT - 1) : '0;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic          s0_q;
        logic          s1_q;
        state_t        state_q;
        logic          rise_q;
        logic          fall_q;
        logic [LW-1:0] lock_q;
        logic          unlocked;
        logic          press_acc;
        logic          rel_acc;

        assign unlocked  = (lock_q == '0);
        assign press_acc = en & unlocked & (state_q == ST_IDLE) & s1_q;
        assign rel_acc   = en & unlocked & (state_q == ST_PRESSED) & ~s1_q;

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                s0_q    <= 1'b0;
                s1_q    <= 1'b0;
                state_q <= ST_IDLE;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                lock_q  <= '0;
            end else begin
                s0_q   <= button[i];
                s1_q   <= s0_q;
                rise_q <= press_acc;
                fall_q <= rel_acc;
                if (state_q == ST_IDLE) begin
                    if (press_acc) state_q <= ST_PRESSED;
                end else begin
                    if (rel_acc) state_q <= ST_IDLE;
                end
                // Lockout keeps counting down even while en is low.
                if (press_acc || rel_acc)
                    lock_q <= LOCK_LOAD;
                else if (!unlocked)
                    lock_q <= lock_q - LW'(1);
            end
        end

        assign held[i] = (state_q == ST_PRESSED);
        assign rise[i] = rise_q;
        assign fall[i] = fall_q;

        if (REPEAT > 0) begin : g_rpt
            logic [RW-1:0] rpt_cnt_q;
            logic          rpt_q;

            // A release on an expiry edge wins, so accepts clear the counter first.
            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    rpt_cnt_q <= '0;
                    rpt_q     <= 1'b0;
                end else if (press_acc || rel_acc || !en || state_q != ST_PRESSED) begin
                    rpt_cnt_q <= '0;
                    rpt_q     <= 1'b0;
                end else if (rpt_cnt_q == RPT_LAST) begin
                    rpt_cnt_q <= '0;
                    rpt_q     <= 1'b1;
                end else begin
                    rpt_cnt_q <= rpt_cnt_q + RW'(1);
                    rpt_q     <= 1'b0;
                end
            end

            assign rpt[i] = rpt_q;
        end else begin : g_no_rpt
            assign rpt[i] = 1'b0;
        end
    end
endmodule

// File: tb/tb_button_debounce_bank.sv
// Bench for button_debounce_bank: directed scenarios followed by random button
// and enable activity, checked against an edge-indexed reference model.
module tb_button_debounce_bank;
    localparam int CH      = 4;
    localparam int LOCKOUT = 16;
    localparam int REPEAT  = 8;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          en = 1'b1;
    logic [CH-1:0] button = '0;
    logic [CH-1:0] held, rise, fall, rpt;

    button_debounce_bank #(
        .CHANNELS(CH),
        .LOCKOUT (LOCKOUT),
        .REPEAT  (REPEAT)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (en),
        .button(button),
        .held  (held),
        .rise  (rise),
        .fall  (fall),
        .rpt   (rpt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: edges are numbered by k; a channel accepts at edge k when enabled,
    // at least LOCKOUT+1 edges after its previous accept, and the button level
    // sampled two edges earlier differs from the debounced level. Repeat fires
    // every REPEAT edges after the latest accept or en-low edge while held.
    int            k = 0;
    logic [CH-1:0] hist0 = '0;
    logic [CH-1:0] hist1 = '0;
    logic [CH-1:0] held_m = '0;
    logic [CH-1:0] rise_m = '0;
    logic [CH-1:0] fall_m = '0;
    logic [CH-1:0] rpt_m = '0;
    int            last_acc[CH];
    int            ref_e[CH];

    task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist0  = '0;
        hist1  = '0;
        held_m = '0;
        rise_m = '0;
        fall_m = '0;
        rpt_m  = '0;
        for (int c = 0; c < CH; c++) begin
            last_acc[c] = -1000;
            ref_e[c]    = k;
        end
    endtask

    task automatic step(input logic [CH-1:0] b, input logic e);
        logic [CH-1:0] lvl;
        button = b;
        en     = e;
        lvl    = hist1;
        hist1  = hist0;
        hist0  = b;
        for (int c = 0; c < CH; c++) begin
            logic acc;
            acc       = e && (k >= last_acc[c] + LOCKOUT + 1) && (lvl[c] != held_m[c]);
            rise_m[c] = acc && lvl[c];
            fall_m[c] = acc && !lvl[c];
            rpt_m[c]  = !acc && held_m[c] && e && (k > ref_e[c]) && (((k - ref_e[c]) % REPEAT) == 0);
            if (acc) begin
                held_m[c]   = lvl[c];
                last_acc[c] = k;
                ref_e[c]    = k;
            end else if (!e) begin
                ref_e[c] = k;
            end
        end
        @(posedge clk);
        #1;
        check("held", held, held_m);
        check("rise", rise, rise_m);
        check("fall", fall, fall_m);
        check("rpt", rpt, rpt_m);
        k++;
    endtask

    task automatic async_reset();
        #2 n_rst = 1'b0;
        #1;
        check("rst_held", held, '0);
        check("rst_rise", rise, '0);
        check("rst_fall", fall, '0);
        check("rst_rpt", rpt, '0);
        @(posedge clk);
        #1;
        check("rst_hold_held", held, '0);
        @(negedge clk);
        n_rst = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [CH-1:0] b;
        logic          e;
        model_reset();
        b = '0;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("por_held", held, '0);
        check("por_pulses", rise | fall | rpt, '0);
        @(negedge clk);
        n_rst = 1'b1;

        // Single press on channel 0, held
        b[0] = 1'b1;
        repeat (20) step(b, 1'b1);

        // Bounce on channel 1 after its accept, ending high
        b[1] = 1'b1;
        repeat (3) step(b, 1'b1);
        for (int t = 0; t < 4; t++) begin
            b[1] = ~b[1];
            repeat (3) step(b, 1'b1);
        end
        repeat (20) step(b, 1'b1);

        // Release during lockout on channel 3
        b[3] = 1'b1;
        repeat (5) step(b, 1'b1);
        b[3] = 1'b0;
        repeat (25) step(b, 1'b1);

        // Auto-repeat on channel 2, release coinciding with a repeat edge
        b[2] = 1'b1;
        repeat (40) step(b, 1'b1);
        b[2] = 1'b0;
        repeat (25) step(b, 1'b1);

        // Enable gating on channel 3
        b[3] = 1'b1;
        repeat (10) step(b, 1'b0);
        step(b, 1'b1);
        check("en_rise3", rise & 4'b1000, 4'b1000);
        repeat (20) step(b, 1'b1);

        // Asynchronous reset mid-hold with lockout at 7
        b = '0;
        repeat (25) step(b, 1'b1);
        b[1] = 1'b1;
        repeat (12) step(b, 1'b1);
        async_reset();
        repeat (3) step(b, 1'b1);
        check("post_rst_rise1", rise, 4'b0010);
        repeat (20) step(b, 1'b1);

        // Random activity
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 9) == 0) b[c] = ~b[c];
            e = ($urandom_range(0, 15) != 0);
            step(b, e);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
